// File: rtl/dcache_data_array_port.sv
// dcache_data_array_port: data-array stage fed by the DCache data-access arbiter.
// Holds a WAYS x ROWS store of DATA_W-bit words with byte-masked writes and a
// registered read of every way in one cycle. Out of reset it clears every row
// before it raises ready.
// Optional feature: define DCACHE_DATA_PARITY_EN to keep one even-parity bit per
// byte per way and report per-way parity mismatches on reads.
module dcache_data_array_port #(
  parameter int WAYS   = 4,
  parameter int ROWS   = 512,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_req_valid,
  output logic                     io_req_ready,
  input  logic [ADDR_W-1:0]        io_req_bits_addr,
  input  logic                     io_req_bits_write,
  input  logic [DATA_W-1:0]        io_req_bits_wdata,
  input  logic [DATA_W/8-1:0]      io_req_bits_eccMask,
  input  logic [WAYS-1:0]          io_req_bits_way_en,
  input  logic                     io_req_bits_flip_par,
  output logic                     io_resp_valid,
  output logic [WAYS*DATA_W-1:0]   io_resp_bits_data,
  output logic [WAYS-1:0]          io_resp_bits_parity_err,
  output logic                     io_init_done
);

  localparam int LANES = DATA_W / 8;
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [ROW_W-1:0]       initCnt_q, initCnt_d;
  logic                   respValid_q;
  logic [WAYS*DATA_W-1:0] respData_q;

  logic [DATA_W-1:0]      mem [WAYS][ROWS];

  logic                   reqFire;
  logic                   rdFire;
  logic [ROW_W-1:0]       reqRow;
  logic [ROW_W-1:0]       wrRow;
  logic [DATA_W-1:0]      wrData;
  logic [WAYS-1:0][LANES-1:0] wrByteEn;
  logic [WAYS*DATA_W-1:0] rdData;

  assign io_req_ready  = (state_q == ST_READY);
  assign io_init_done  = (state_q == ST_READY);
  assign reqFire       = io_req_valid && io_req_ready;
  assign rdFire        = reqFire && !io_req_bits_write;
  assign reqRow        = io_req_bits_addr[3 +: ROW_W];
  assign io_resp_valid = respValid_q;
  assign io_resp_bits_data = respData_q;

  // Next-state: the clear walk advances one row per cycle, then READY is sticky until reset.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    if (state_q == ST_INIT) begin
      initCnt_d = initCnt_q + 1'b1;
      if (initCnt_q == ROW_W'(ROWS - 1)) begin
        state_d   = ST_READY;
        initCnt_d = '0;
      end
    end
  end

  // Write port selection: the clear walk owns the port during INIT, the request owns it after.
  always_comb begin
    wrRow    = initCnt_q;
    wrData   = '0;
    wrByteEn = '0;
    if (state_q == ST_INIT) begin
      wrByteEn = '1;
    end else if (reqFire && io_req_bits_write) begin
      wrRow  = reqRow;
      wrData = io_req_bits_wdata;
      for (int w = 0; w < WAYS; w++) begin
        if (io_req_bits_way_en[w]) begin
          wrByteEn[w] = io_req_bits_eccMask;
        end
      end
    end
  end

  // Read mux: gather the addressed row from every way.
  always_comb begin
    rdData = '0;
    for (int w = 0; w < WAYS; w++) begin
      rdData[w*DATA_W +: DATA_W] = mem[w][reqRow];
    end
  end

  // Data storage: byte-lane writes, contents intentionally not reset.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < LANES; b++) begin
        if (wrByteEn[w][b]) begin
          mem[w][wrRow][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  // Control and response registers; reset drops any response in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      initCnt_q   <= '0;
      respValid_q <= 1'b0;
      respData_q  <= '0;
    end else begin
      state_q     <= state_d;
      initCnt_q   <= initCnt_d;
      respValid_q <= rdFire;
      if (rdFire) begin
        respData_q <= rdData;
      end
    end
  end

`ifdef DCACHE_DATA_PARITY_EN
  logic [LANES-1:0] parMem [WAYS][ROWS];
  logic [LANES-1:0] wrPar;
  logic [WAYS-1:0]  rdErr;
  logic [WAYS-1:0]  parErr_q;
  logic [2:0]       unusedAddrBits;

  assign unusedAddrBits          = io_req_bits_addr[2:0];
  assign io_resp_bits_parity_err = parErr_q;

  // Parity to store per byte; zero during the clear walk since cleared bytes have even parity.
  always_comb begin
    wrPar = '0;
    if (state_q == ST_READY) begin
      for (int b = 0; b < LANES; b++) begin
        wrPar[b] = (^io_req_bits_wdata[8*b +: 8]) ^ io_req_bits_flip_par;
      end
    end
  end

  // Parity check: any byte of a way disagreeing with its stored bit flags that way.
  always_comb begin
    rdErr = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < LANES; b++) begin
        if ((^mem[w][reqRow][8*b +: 8]) != parMem[w][reqRow][b]) begin
          rdErr[w] = 1'b1;
        end
      end
    end
  end

  // Parity storage: only the bytes actually written get new parity.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < LANES; b++) begin
        if (wrByteEn[w][b]) begin
          parMem[w][wrRow][b] <= wrPar[b];
        end
      end
    end
  end

  // Parity error register, captured with the read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parErr_q <= '0;
    end else if (rdFire) begin
      parErr_q <= rdErr;
    end
  end
`else
  logic [3:0] unusedBits;

  assign unusedBits              = {io_req_bits_addr[2:0], io_req_bits_flip_par};
  assign io_resp_bits_parity_err = '0;
`endif

endmodule

// File: tb/tb_dcache_data_array_port.sv
// tb_dcache_data_array_port: directed self-checking bench for dcache_data_array_port
// with default parameters (4 ways, 512 rows, 64-bit words).
module tb_dcache_data_array_port;

  logic         clock;
  logic         reset;
  logic         reqValid;
  logic         reqReady;
  logic [11:0]  reqAddr;
  logic         reqWrite;
  logic [63:0]  reqWdata;
  logic [7:0]   reqMask;
  logic [3:0]   reqWayEn;
  logic         reqFlip;
  logic         respValid;
  logic [255:0] respData;
  logic [3:0]   respParErr;
  logic         initDone;

  int errors = 0;
  int checks = 0;
  int initCycles;

  dcache_data_array_port dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_req_valid            (reqValid),
    .io_req_ready            (reqReady),
    .io_req_bits_addr        (reqAddr),
    .io_req_bits_write       (reqWrite),
    .io_req_bits_wdata       (reqWdata),
    .io_req_bits_eccMask     (reqMask),
    .io_req_bits_way_en      (reqWayEn),
    .io_req_bits_flip_par    (reqFlip),
    .io_resp_valid           (respValid),
    .io_resp_bits_data       (respData),
    .io_resp_bits_parity_err (respParErr),
    .io_init_done            (initDone)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the following negedge with valid still high.
  task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [63:0] data,
                               input logic [7:0] mask, input logic [3:0] wayEn, input logic flip);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqWdata = data;
    reqMask  = mask;
    reqWayEn = wayEn;
    reqFlip  = flip;
    @(negedge clock);
  endtask

  task automatic idleCycle();
    reqValid = 1'b0;
    reqWrite = 1'b0;
    @(negedge clock);
  endtask

  // Count cycles from reset release until ready rises, bounded.
  task automatic waitInit(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!reqReady && n < 2000);
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    reqMask  = '0;
    reqWayEn = '0;
    reqFlip  = 1'b0;
    $display("[TB] start");
    repeat (3) @(negedge clock);

    checkOutput("rstReady",     reqReady,   0);
    checkOutput("rstRespValid", respValid,  0);
    checkOutput("rstRespData",  respData,   0);
    checkOutput("rstParErr",    respParErr, 0);
    checkOutput("rstInitDone",  initDone,   0);

    reset = 1'b0;
    waitInit(initCycles);
    checkOutput("initCycles", initCycles, 512);
    checkOutput("initDone",   initDone,   1);

    // Last row is cleared
    applyStimulus(1'b0, 12'hFF8, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("row1FFValid",  respValid,  1);
    checkOutput("row1FFData",   respData,   0);
    checkOutput("row1FFParErr", respParErr, 0);

    // Partial byte mask on one way, read immediately after
    applyStimulus(1'b1, 12'h010, 64'h1122334455667788, 8'h0F, 4'h2, 1'b0);
    checkOutput("wrNoResp", respValid, 0);
    applyStimulus(1'b0, 12'h010, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("maskValid", respValid, 1);
    checkOutput("maskData", respData, {64'h0, 64'h0, 64'h0000000055667788, 64'h0});
    idleCycle();
    checkOutput("maskValidDrop", respValid, 0);

    // Full write, read with nonzero low address bits
    applyStimulus(1'b1, 12'h008, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 4'hF, 1'b0);
    applyStimulus(1'b0, 12'h00F, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("lowBitsData", respData, {4{64'hA5A5A5A5A5A5A5A5}});

    // Back-to-back reads of rows 1, 2, 3
    applyStimulus(1'b1, 12'h008, 64'h1111111111111111, 8'hFF, 4'hF, 1'b0);
    applyStimulus(1'b1, 12'h010, 64'h2222222222222222, 8'hFF, 4'hF, 1'b0);
    applyStimulus(1'b1, 12'h018, 64'h3333333333333333, 8'hFF, 4'hF, 1'b0);
    applyStimulus(1'b0, 12'h008, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("b2bValid1", respValid, 1);
    checkOutput("b2bData1",  respData,  {4{64'h1111111111111111}});
    applyStimulus(1'b0, 12'h010, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("b2bValid2", respValid, 1);
    checkOutput("b2bData2",  respData,  {4{64'h2222222222222222}});
    applyStimulus(1'b0, 12'h018, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("b2bValid3", respValid, 1);
    checkOutput("b2bData3",  respData,  {4{64'h3333333333333333}});
    idleCycle();
    checkOutput("b2bValidLow", respValid, 0);
    checkOutput("b2bDataHeld", respData,  {4{64'h3333333333333333}});

    // No-op writes: zero way enable, then zero byte mask
    applyStimulus(1'b1, 12'h018, 64'hDEADBEEFDEADBEEF, 8'hFF, 4'h0, 1'b0);
    applyStimulus(1'b1, 12'h018, 64'hDEADBEEFDEADBEEF, 8'h00, 4'hF, 1'b0);
    applyStimulus(1'b0, 12'h018, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("noopData", respData, {4{64'h3333333333333333}});

    // Parity: flipped parity flags way 0, clean rewrite clears it
    applyStimulus(1'b1, 12'h028, 64'h00000000000000FF, 8'h01, 4'h1, 1'b1);
    applyStimulus(1'b0, 12'h028, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("parFlipData", respData, {64'h0, 64'h0, 64'h0, 64'h00000000000000FF});
`ifdef DCACHE_DATA_PARITY_EN
    checkOutput("parFlipErr", respParErr, 4'h1);
`else
    checkOutput("parFlipErr", respParErr, 4'h0);
`endif
    applyStimulus(1'b1, 12'h028, 64'h00000000000000FF, 8'h01, 4'h1, 1'b0);
    applyStimulus(1'b0, 12'h028, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("parCleanErr", respParErr, 4'h0);

    // Reset in the middle of READY with a response outstanding
    applyStimulus(1'b0, 12'h010, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("inflightValid", respValid, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstValid", respValid, 0);
    checkOutput("midRstReady", reqReady,  0);
    checkOutput("midRstData",  respData,  0);
    reqValid = 1'b0;
    reqWrite = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    waitInit(initCycles);
    checkOutput("reinitCycles", initCycles, 512);

    applyStimulus(1'b0, 12'h008, 64'h0, 8'h00, 4'h0, 1'b0);
    checkOutput("reinitValid", respValid, 1);
    checkOutput("reinitData",  respData,  0);
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
